// File: rtl/edge_fifo_ctrl.sv
// edge_fifo_ctrl: synchronous FIFO driven by push buttons or clean strobes.
//   Push-button mode synchronises wr/rd through two flops and raises one
//   command per press, when the button is released. Strobe mode uses wr/rd
//   directly, one command per high cycle.
//   Also provides an occupancy count, almost-full/almost-empty flags,
//   simultaneous read/write, a read-valid pulse and sticky error flags.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   wr, rd            write/read command (button level or strobe)
//   in [DW]           write data, sampled on the accepting edge
//   clr_err           clears overflow/underflow
//   out [DW]          registered read data; out_valid pulses when it updates
//   empty, full, almost_full, almost_empty, count [AW+1]
//   overflow, underflow  sticky rejected-write / rejected-read flags
module edge_fifo_ctrl #(
  parameter int DW        = 3,
  parameter int AW        = 2,
  parameter int EDGE_MODE = 1,
  parameter int AF_TH     = 3,
  parameter int AE_TH     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] in,
  input  logic          clr_err,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AF    = (AW+1)'(AF_TH);
  localparam logic [AW:0] LP_AE    = (AW+1)'(AE_TH);

  logic          w_wr_ev, w_rd_ev, w_wr_ok, w_rd_ok;
  logic [AW:0]   w_cnt_nxt;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_out;
  logic          r_out_valid, r_empty, r_full, r_af, r_ae, r_ovf, r_udf;

  // Command event generation
  if (EDGE_MODE != 0) begin : g_edge
    logic r_wr_s1, r_wr_s2, r_rd_s1, r_rd_s2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_s1 <= 1'b0;
        r_wr_s2 <= 1'b0;
        r_rd_s1 <= 1'b0;
        r_rd_s2 <= 1'b0;
      end else begin
        r_wr_s1 <= wr;
        r_wr_s2 <= r_wr_s1;
        r_rd_s1 <= rd;
        r_rd_s2 <= r_rd_s1;
      end
    end
    // Falling edge of the synchronised level: one event per press, on release
    assign w_wr_ev = r_wr_s2 & ~r_wr_s1;
    assign w_rd_ev = r_rd_s2 & ~r_rd_s1;
  end else begin : g_strobe
    assign w_wr_ev = wr;
    assign w_rd_ev = rd;
  end

  // A read in the same cycle frees a slot, so a full FIFO can still take a write
  assign w_rd_ok = w_rd_ev & ~r_empty;
  assign w_wr_ok = w_wr_ev & (~r_full | w_rd_ok);

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_ok && !w_rd_ok)      w_cnt_nxt = r_count + 1'b1;
    else if (w_rd_ok && !w_wr_ok) w_cnt_nxt = r_count - 1'b1;
  end

  // Storage is not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wp] <= in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_af        <= (AF_TH == 0);
      r_ae        <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + 1'b1;
      if (w_rd_ok) begin
        r_rp  <= r_rp + 1'b1;
        r_out <= r_mem[r_rp];
      end
      r_out_valid <= w_rd_ok;
      r_count     <= w_cnt_nxt;
      // Flags follow the next count so they line up with count every cycle
      r_empty     <= (w_cnt_nxt == '0);
      r_full      <= (w_cnt_nxt == LP_DEPTH);
      r_af        <= (w_cnt_nxt >= LP_AF);
      r_ae        <= (w_cnt_nxt <= LP_AE);
      // A fresh error wins over a same-cycle clear
      r_ovf       <= (r_ovf & ~clr_err) | (w_wr_ev & ~w_wr_ok);
      r_udf       <= (r_udf & ~clr_err) | (w_rd_ev & ~w_rd_ok);
    end
  end

  assign out          = r_out;
  assign out_valid    = r_out_valid;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule
